// File: rtl/cpuclk_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpuclk_pkg                                                         |
// | Shared state encoding and parameter defaults for the CPU clock     |
// | switch/divider.                                                    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package cpuclk_pkg;

   localparam int DIV_W_DEF       = 4;
   localparam int SYNC_STAGES_DEF = 2;
   localparam int MIN_LOW_DEF     = 2;

   typedef enum logic [1:0] {
      LS_ALIGN = 2'd0,
      LS_RUN   = 2'd1,
      HS_ALIGN = 2'd2,
      HS_RUN   = 2'd3
   } cpuclk_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_ff                                                            |
// | N-stage single-bit synchroniser with asynchronous active-low reset.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module sync_ff
   import cpuclk_pkg::*;
#(
   parameter int STAGES = SYNC_STAGES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain_q;
   logic [STAGES-1:0] chain_d;

   always_comb begin
      chain_d = {chain_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain_q <= '0;
      end else begin
         chain_q <= chain_d;
      end
   end

   assign q = chain_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/cpuclk_switch_div.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpuclk_switch_div                                                  |
// | Glitch-free CPU clock switch between a divided hsclk_in and a      |
// | synchronised lsclk_in. Optional macro: LONG_LS_PHI1_TO_HS_PHI1_EN  |
// | holds HS entry until an LS rise has been seen in HS_ALIGN.         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module cpuclk_switch_div
   import cpuclk_pkg::*;
#(
   parameter int DIV_W       = DIV_W_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int MIN_LOW     = MIN_LOW_DEF
) (
   input  logic             hsclk_in,
   input  logic             rst_b,
   input  logic             lsclk_in,
   input  logic             hsclk_sel,
   input  logic [DIV_W-1:0] cpuclk_div_sel,
   output logic             clkout,
   output logic             hsclk_selected,
   output logic             lsclk_selected,
   output logic             switch_busy
);

   localparam logic [DIV_W-1:0] MIN_LOW_CNT = DIV_W'(MIN_LOW - 1);
   localparam logic [DIV_W-1:0] CNT_ONE     = DIV_W'(1);

   cpuclk_state_e    state_q, state_d;
   logic             clkout_q, clkout_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             ls_prev_q;
   logic             hs_sel_q, hs_sel_d;
   logic             ls_sel_q, ls_sel_d;
   logic             ls_sync;
   logic             ls_rise;
   logic             align_done;

   sync_ff #(
      .STAGES (SYNC_STAGES)
   ) u_ls_sync (
      .clk   (hsclk_in),
      .rst_n (rst_b),
      .d     (lsclk_in),
      .q     (ls_sync)
   );

   assign ls_rise = ls_sync & ~ls_prev_q;

`ifdef LONG_LS_PHI1_TO_HS_PHI1_EN
   logic seen_rise_q, seen_rise_d;

   // Held clear outside HS_ALIGN, so it is always clear on entry.
   always_comb begin
      seen_rise_d = 1'b0;
      if (state_q == HS_ALIGN) begin
         seen_rise_d = seen_rise_q | ls_rise;
      end
   end

   always_ff @(posedge hsclk_in or negedge rst_b) begin
      if (!rst_b) begin
         seen_rise_q <= 1'b0;
      end else begin
         seen_rise_q <= seen_rise_d;
      end
   end

   assign align_done = (cnt_q == '0) && (seen_rise_q || ls_rise);
`else
   assign align_done = (cnt_q == '0);
`endif

   always_comb begin
      state_d  = state_q;
      clkout_d = clkout_q;
      cnt_d    = cnt_q;
      div_d    = div_q;
      case (state_q)
         LS_RUN: begin
            clkout_d = ls_sync;
            // Leave only once the LS high phase has fully drained.
            if (hsclk_sel && !ls_sync && !clkout_q) begin
               state_d  = HS_ALIGN;
               cnt_d    = MIN_LOW_CNT;
               clkout_d = 1'b0;
            end
         end
         HS_ALIGN: begin
            clkout_d = 1'b0;
            if (!hsclk_sel) begin
               state_d = LS_ALIGN;
            end else if (align_done) begin
               state_d  = HS_RUN;
               clkout_d = 1'b1;
               div_d    = cpuclk_div_sel;
               cnt_d    = cpuclk_div_sel;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         HS_RUN: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_ONE;
            end else if (!clkout_q && !hsclk_sel) begin
               state_d  = LS_ALIGN;
               clkout_d = 1'b0;
            end else begin
               clkout_d = ~clkout_q;
               div_d    = cpuclk_div_sel;
               cnt_d    = cpuclk_div_sel;
            end
         end
         default: begin
            clkout_d = 1'b0;
            if (hsclk_sel) begin
               state_d = HS_ALIGN;
               cnt_d   = MIN_LOW_CNT;
            end else if (ls_rise) begin
               state_d  = LS_RUN;
               clkout_d = 1'b1;
            end
         end
      endcase
   end

   assign hs_sel_d = (state_d == HS_RUN);
   assign ls_sel_d = (state_d == LS_RUN);

   always_ff @(posedge hsclk_in or negedge rst_b) begin
      if (!rst_b) begin
         state_q   <= LS_ALIGN;
         clkout_q  <= 1'b0;
         cnt_q     <= '0;
         div_q     <= '0;
         ls_prev_q <= 1'b0;
         hs_sel_q  <= 1'b0;
         ls_sel_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         clkout_q  <= clkout_d;
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         ls_prev_q <= ls_sync;
         hs_sel_q  <= hs_sel_d;
         ls_sel_q  <= ls_sel_d;
      end
   end

   // The running phase counter can never exceed the divide latched for it.
   a_cnt_within_div: assert property (@(posedge hsclk_in) disable iff (!rst_b)
      (state_q == HS_RUN) |-> (cnt_q <= div_q));

   assign clkout         = clkout_q;
   assign hsclk_selected = hs_sel_q;
   assign lsclk_selected = ls_sel_q;
   assign switch_busy    = (state_q == LS_ALIGN) || (state_q == HS_ALIGN) ||
                           ((state_q == LS_RUN) && hsclk_sel) ||
                           ((state_q == HS_RUN) && !hsclk_sel);

endmodule
`default_nettype wire

// File: tb/tb_cpuclk_switch_div.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cpuclk_switch_div                                               |
// | Directed self-checking bench for cpuclk_switch_div.                |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_cpuclk_switch_div;

   logic       hsclk_in       = 1'b0;
   logic       rst_b          = 1'b0;
   logic       lsclk_in       = 1'b0;
   logic       hsclk_sel      = 1'b0;
   logic [3:0] cpuclk_div_sel = 4'd0;
   logic       clkout;
   logic       hsclk_selected;
   logic       lsclk_selected;
   logic       switch_busy;

   int   total   = 0;
   int   bad     = 0;
   logic ls_en   = 1'b0;
   int   ls_half = 4;
   int   ls_cnt  = 0;
   logic [2:0] hist;

   cpuclk_switch_div #(
      .DIV_W       (4),
      .SYNC_STAGES (2),
      .MIN_LOW     (2)
   ) dut (
      .hsclk_in       (hsclk_in),
      .rst_b          (rst_b),
      .lsclk_in       (lsclk_in),
      .hsclk_sel      (hsclk_sel),
      .cpuclk_div_sel (cpuclk_div_sel),
      .clkout         (clkout),
      .hsclk_selected (hsclk_selected),
      .lsclk_selected (lsclk_selected),
      .switch_busy    (switch_busy)
   );

   always #5 hsclk_in = ~hsclk_in;

   // LS clock: 2*ls_half hsclk cycles per period, changing on falling edges.
   always @(negedge hsclk_in) begin
      if (!ls_en) begin
         lsclk_in = 1'b0;
         ls_cnt   = 0;
      end else begin
         ls_cnt = ls_cnt + 1;
         if (ls_cnt >= ls_half) begin
            lsclk_in = ~lsclk_in;
            ls_cnt   = 0;
         end
      end
   end

   // lsclk_in as seen on the last three rising edges; hist[2] is what clkout shows in LS_RUN.
   always @(posedge hsclk_in or negedge rst_b) begin
      if (!rst_b) hist <= 3'b000;
      else        hist <= {hist[1:0], lsclk_in};
   end

   task automatic measure(input logic lvl, output int n);
      n = 0;
      while (clkout === lvl && n < 200) begin
         n++;
         @(negedge hsclk_in);
      end
   endtask

   task automatic wait_level(input logic lvl, output bit ok);
      int k = 0;
      while (clkout !== lvl && k < 200) begin
         k++;
         @(negedge hsclk_in);
      end
      ok = (clkout === lvl);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge hsclk_in);
      total++; if (clkout !== 1'b0) begin bad++; $display("FAIL reset_clkout got=%b want=0", clkout); end
      total++; if (hsclk_selected !== 1'b0) begin bad++; $display("FAIL reset_hs_sel got=%b want=0", hsclk_selected); end
      total++; if (lsclk_selected !== 1'b0) begin bad++; $display("FAIL reset_ls_sel got=%b want=0", lsclk_selected); end
      total++; if (switch_busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b want=1", switch_busy); end
   endtask

   task automatic test_ls_track();
      rst_b = 1'b1;
      ls_en = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge hsclk_in);
         total++;
         if (clkout !== hist[2]) begin
            bad++; $display("FAIL ls_track cyc=%0d got=%b want=%b", i, clkout, hist[2]);
         end
      end
      total++; if (lsclk_selected !== 1'b1) begin bad++; $display("FAIL ls_track_ls_sel got=%b want=1", lsclk_selected); end
      total++; if (hsclk_selected !== 1'b0) begin bad++; $display("FAIL ls_track_hs_sel got=%b want=0", hsclk_selected); end
      total++; if (switch_busy !== 1'b0) begin bad++; $display("FAIL ls_track_busy got=%b want=0", switch_busy); end
   endtask

   task automatic test_ls_to_hs();
      bit ok;
      int n;
      cpuclk_div_sel = 4'd1;
      wait_level(1'b0, ok);
      wait_level(1'b1, ok);
      total++; if (!ok) begin bad++; $display("FAIL ls2hs_wait_high got=%b want=1", clkout); end
      hsclk_sel = 1'b1;
      #1;
      total++; if (switch_busy !== 1'b1) begin bad++; $display("FAIL ls2hs_busy got=%b want=1", switch_busy); end
      // LS high phase must run to completion under the HS request.
      n = 0;
      while (clkout === 1'b1 && n < 50) begin
         total++;
         if (hist[2] !== 1'b1) begin bad++; $display("FAIL ls2hs_high_cut ls=%b clkout=%b want_ls=1", hist[2], clkout); end
         n++;
         @(negedge hsclk_in);
      end
      total++; if (hist[2] !== 1'b0) begin bad++; $display("FAIL ls2hs_high_end ls=%b want=0", hist[2]); end
      // One low cycle still in LS_RUN, then MIN_LOW cycles in HS_ALIGN.
      measure(1'b0, n);
`ifdef LONG_LS_PHI1_TO_HS_PHI1_EN
      ok = (n >= ls_half);
`else
      ok = (n == 3);
`endif
      total++; if (!ok) begin bad++; $display("FAIL ls2hs_low got=%0d want=3 (>=%0d with long PHI1)", n, ls_half); end
      total++; if (hsclk_selected !== 1'b1) begin bad++; $display("FAIL ls2hs_hs_sel got=%b want=1", hsclk_selected); end
      total++; if (switch_busy !== 1'b0) begin bad++; $display("FAIL ls2hs_busy_run got=%b want=0", switch_busy); end
      measure(1'b1, n);
      total++; if (n != 2) begin bad++; $display("FAIL ls2hs_hs_high got=%0d want=2", n); end
      measure(1'b0, n);
      total++; if (n != 2) begin bad++; $display("FAIL ls2hs_hs_low got=%0d want=2", n); end
      measure(1'b1, n);
      total++; if (n != 2) begin bad++; $display("FAIL ls2hs_hs_high2 got=%0d want=2", n); end
   endtask

   task automatic test_div_change();
      int n;
      cpuclk_div_sel = 4'd0;
      measure(1'b0, n);
      total++; if (n != 2) begin bad++; $display("FAIL div_old_phase got=%0d want=2", n); end
      measure(1'b1, n);
      total++; if (n != 1) begin bad++; $display("FAIL div0_high got=%0d want=1", n); end
      measure(1'b0, n);
      total++; if (n != 1) begin bad++; $display("FAIL div0_low got=%0d want=1", n); end
      cpuclk_div_sel = 4'd2;
      measure(1'b1, n);
      total++; if (n != 1) begin bad++; $display("FAIL div_change_cur got=%0d want=1", n); end
      measure(1'b0, n);
      total++; if (n != 3) begin bad++; $display("FAIL div2_low got=%0d want=3", n); end
      measure(1'b1, n);
      total++; if (n != 3) begin bad++; $display("FAIL div2_high got=%0d want=3", n); end
      total++; if (hsclk_selected !== 1'b1) begin bad++; $display("FAIL div_hs_sel got=%b want=1", hsclk_selected); end
   endtask

   task automatic test_hs_to_ls();
      int n;
      cpuclk_div_sel = 4'd3;
      measure(1'b0, n);
      total++; if (n != 3) begin bad++; $display("FAIL hs2ls_pre_low got=%0d want=3", n); end
      hsclk_sel = 1'b0;
      #1;
      total++; if (switch_busy !== 1'b1) begin bad++; $display("FAIL hs2ls_busy got=%b want=1", switch_busy); end
      measure(1'b1, n);
      total++; if (n != 4) begin bad++; $display("FAIL hs2ls_high got=%0d want=4", n); end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (clkout !== 1'b0 || hsclk_selected !== 1'b1) begin
            bad++; $display("FAIL hs2ls_low cyc=%0d clkout=%b hs_sel=%b want=0/1", i, clkout, hsclk_selected);
         end
         @(negedge hsclk_in);
      end
      total++;
      if (clkout !== 1'b0 || hsclk_selected !== 1'b0 || switch_busy !== 1'b1) begin
         bad++; $display("FAIL hs2ls_align clkout=%b hs_sel=%b busy=%b want=0/0/1", clkout, hsclk_selected, switch_busy);
      end
      n = 0;
      while (clkout === 1'b0 && n < 200) begin
         total++;
         if (lsclk_selected !== 1'b0) begin bad++; $display("FAIL hs2ls_wait_ls_sel got=%b want=0", lsclk_selected); end
         n++;
         @(negedge hsclk_in);
      end
      total++; if (lsclk_selected !== 1'b1) begin bad++; $display("FAIL hs2ls_ls_sel got=%b want=1", lsclk_selected); end
      measure(1'b1, n);
      total++; if (n != ls_half) begin bad++; $display("FAIL hs2ls_first_ls_high got=%0d want=%0d", n, ls_half); end
   endtask

   task automatic test_abort_align();
      int n;
      // Just after an LS fall: clkout and the synced LS are both low.
      hsclk_sel = 1'b1;
      @(negedge hsclk_in);
      total++;
      if (clkout !== 1'b0 || hsclk_selected !== 1'b0 || lsclk_selected !== 1'b0 || switch_busy !== 1'b1) begin
         bad++; $display("FAIL abort_hs_align1 clk=%b hs=%b ls=%b busy=%b want=0/0/0/1", clkout, hsclk_selected, lsclk_selected, switch_busy);
      end
      hsclk_sel = 1'b0;
      @(negedge hsclk_in);
      total++;
      if (clkout !== 1'b0 || lsclk_selected !== 1'b0 || switch_busy !== 1'b1) begin
         bad++; $display("FAIL abort_ls_align1 clk=%b ls=%b busy=%b want=0/0/1", clkout, lsclk_selected, switch_busy);
      end
      hsclk_sel = 1'b1;
      @(negedge hsclk_in);
      total++;
      if (clkout !== 1'b0 || hsclk_selected !== 1'b0 || lsclk_selected !== 1'b0) begin
         bad++; $display("FAIL abort_hs_align2 clk=%b hs=%b ls=%b want=0/0/0", clkout, hsclk_selected, lsclk_selected);
      end
      hsclk_sel = 1'b0;
      @(negedge hsclk_in);
      total++;
      if (clkout !== 1'b0 || hsclk_selected !== 1'b0 || switch_busy !== 1'b1) begin
         bad++; $display("FAIL abort_ls_align2 clk=%b hs=%b busy=%b want=0/0/1", clkout, hsclk_selected, switch_busy);
      end
      n = 0;
      while (clkout === 1'b0 && n < 200) begin
         n++;
         @(negedge hsclk_in);
      end
      total++; if (lsclk_selected !== 1'b1) begin bad++; $display("FAIL abort_ls_sel got=%b want=1", lsclk_selected); end
      measure(1'b1, n);
      total++; if (n != ls_half) begin bad++; $display("FAIL abort_ls_high got=%0d want=%0d", n, ls_half); end
   endtask

   task automatic test_async_reset();
      int k = 0;
      hsclk_sel      = 1'b1;
      cpuclk_div_sel = 4'd3;
      while (!(hsclk_selected === 1'b1 && clkout === 1'b1) && k < 300) begin
         k++;
         @(negedge hsclk_in);
      end
      total++; if (hsclk_selected !== 1'b1 || clkout !== 1'b1) begin bad++; $display("FAIL arst_reach_hs hs=%b clk=%b want=1/1", hsclk_selected, clkout); end
      #2 rst_b = 1'b0;
      #1;
      total++; if (clkout !== 1'b0) begin bad++; $display("FAIL arst_clkout got=%b want=0", clkout); end
      total++; if (hsclk_selected !== 1'b0) begin bad++; $display("FAIL arst_hs_sel got=%b want=0", hsclk_selected); end
      total++; if (switch_busy !== 1'b1) begin bad++; $display("FAIL arst_busy got=%b want=1", switch_busy); end
      hsclk_sel = 1'b0;
      @(negedge hsclk_in);
      rst_b = 1'b1;
   endtask

   initial begin
      test_reset();
      test_ls_track();
      test_ls_to_hs();
      test_div_change();
      test_hs_to_ls();
      test_abort_align();
      test_async_reset();
      repeat (2) @(negedge hsclk_in);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
